// File: rtl/stereo_depth_matcher.sv
// ---------------------------------------------------------------------------
// stereo_depth_matcher
//
// Pairs up to MAX_PTS tracked points from camera 1 with up to MAX_PTS
// centroids from camera 2 and turns each pairing into a depth estimate.
// Each camera-1 point, in index order, greedily takes the nearest free
// camera-2 centroid by Manhattan distance, subject to a distance gate.
// Depth is DEPTH_K / |x disparity|, computed by one shared restoring divider.
// A single matcher and a single divider are time-multiplexed by an FSM.
//
// Ports:
//   clk_in           clock
//   rst_in           synchronous active-high reset
//   data_valid_in    input set valid, accepted only while ready_out is high
//   ready_out        high while idle and able to accept a set
//   num_pts_in       active point count minus one (clamped to MAX_PTS)
//   x_in_1, y_in_1   camera-1 point coordinates, point k at slice k
//   x_in_2, y_in_2   camera-2 centroid coordinates, centroid k at slice k
//   depth_out        depth per camera-1 point (0 when unmatched)
//   match_idx_out    assigned centroid index per camera-1 point
//   match_valid_out  per-point matched flag
//   data_valid_out   one-cycle pulse when the output set updates
// ---------------------------------------------------------------------------
module stereo_depth_matcher #(
    parameter int MAX_PTS     = 4,
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10,
    parameter int DEPTH_WIDTH = 8,
    parameter int K_WIDTH     = 16,
    parameter int DEPTH_K     = 2048,
    parameter int MAX_DIST    = 256
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               data_valid_in,
    output logic                               ready_out,
    input  logic [$clog2(MAX_PTS)-1:0]         num_pts_in,
    input  logic [MAX_PTS*X_WIDTH-1:0]         x_in_1,
    input  logic [MAX_PTS*Y_WIDTH-1:0]         y_in_1,
    input  logic [MAX_PTS*X_WIDTH-1:0]         x_in_2,
    input  logic [MAX_PTS*Y_WIDTH-1:0]         y_in_2,
    output logic [MAX_PTS*DEPTH_WIDTH-1:0]     depth_out,
    output logic [MAX_PTS*$clog2(MAX_PTS)-1:0] match_idx_out,
    output logic [MAX_PTS-1:0]                 match_valid_out,
    output logic                               data_valid_out
);

    localparam int IW   = $clog2(MAX_PTS);
    localparam int CW   = $clog2(MAX_PTS + 1);
    localparam int DW   = X_WIDTH + 2;
    localparam int CNTW = $clog2(K_WIDTH + 1);

    localparam logic [DW-1:0]      MAX_DIST_W = DW'(MAX_DIST);
    localparam logic [K_WIDTH-1:0] DEPTH_K_W  = K_WIDTH'(DEPTH_K);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEARCH  = 3'd1;
    localparam logic [2:0] S_RESOLVE = 3'd2;
    localparam logic [2:0] S_DIVIDE  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    function automatic logic [X_WIDTH-1:0] absDiffX(input logic [X_WIDTH-1:0] a,
                                                    input logic [X_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [Y_WIDTH-1:0] absDiffY(input logic [Y_WIDTH-1:0] a,
                                                    input logic [Y_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          n_q, n_d;
    logic [CW-1:0]          i_q, i_d;
    logic [CW-1:0]          j_q, j_d;

    logic [X_WIDTH-1:0]     x1_q [MAX_PTS];
    logic [X_WIDTH-1:0]     x1_d [MAX_PTS];
    logic [Y_WIDTH-1:0]     y1_q [MAX_PTS];
    logic [Y_WIDTH-1:0]     y1_d [MAX_PTS];
    logic [X_WIDTH-1:0]     x2_q [MAX_PTS];
    logic [X_WIDTH-1:0]     x2_d [MAX_PTS];
    logic [Y_WIDTH-1:0]     y2_q [MAX_PTS];
    logic [Y_WIDTH-1:0]     y2_d [MAX_PTS];

    logic [MAX_PTS-1:0]     taken_q, taken_d;
    logic                   found_q, found_d;
    logic [IW-1:0]          best_q, best_d;
    logic [DW-1:0]          bestDist_q, bestDist_d;

    logic [DEPTH_WIDTH-1:0] wDepth_q [MAX_PTS];
    logic [DEPTH_WIDTH-1:0] wDepth_d [MAX_PTS];
    logic [IW-1:0]          wIdx_q [MAX_PTS];
    logic [IW-1:0]          wIdx_d [MAX_PTS];
    logic [MAX_PTS-1:0]     wValid_q, wValid_d;

    logic [DEPTH_WIDTH-1:0] depth_q [MAX_PTS];
    logic [DEPTH_WIDTH-1:0] depth_d [MAX_PTS];
    logic [IW-1:0]          idx_q [MAX_PTS];
    logic [IW-1:0]          idx_d [MAX_PTS];
    logic [MAX_PTS-1:0]     valid_q, valid_d;
    logic                   dataValid_q, dataValid_d;

    logic [X_WIDTH-1:0]     disp_q, disp_d;
    logic [K_WIDTH-1:0]     quot_q, quot_d;
    logic [X_WIDTH-1:0]     rem_q, rem_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic [IW-1:0]          iIdx;
    logic [IW-1:0]          jIdx;
    logic [DW-1:0]          candDist;
    logic [X_WIDTH-1:0]     bestDisp;
    logic [31:0]            npExt;
    logic [CW-1:0]          nAccept;
    logic [X_WIDTH:0]       remShift;
    logic                   remFits;
    logic [X_WIDTH-1:0]     remNext;
    logic [K_WIDTH-1:0]     quotNext;
    logic [DEPTH_WIDTH-1:0] depthSat;
    logic                   advance;

    assign iIdx = i_q[IW-1:0];
    assign jIdx = j_q[IW-1:0];

    // Manhattan distance between the current point and the current candidate,
    // widened so the sum of both axis differences can never wrap.
    assign candDist = DW'(absDiffX(x1_q[iIdx], x2_q[jIdx]))
                    + DW'(absDiffY(y1_q[iIdx], y2_q[jIdx]));

    assign bestDisp = absDiffX(x1_q[iIdx], x2_q[best_q]);

    // Point count is clamped so an oversized request still indexes valid slots.
    assign npExt   = 32'(num_pts_in);
    assign nAccept = (npExt >= 32'(MAX_PTS)) ? CW'(MAX_PTS) : CW'(npExt + 32'd1);

    // One restoring-division step: the dividend shifts out of the top of
    // quot_q into the remainder while quotient bits shift in at the bottom.
    // The remainder is always below the divisor, so it fits in X_WIDTH bits
    // and the subtraction can be done modulo 2^X_WIDTH.
    assign remShift = {rem_q, quot_q[K_WIDTH-1]};
    assign remFits  = (remShift >= {1'b0, disp_q});
    assign remNext  = remFits ? (remShift[X_WIDTH-1:0] - disp_q) : remShift[X_WIDTH-1:0];
    assign quotNext = {quot_q[K_WIDTH-2:0], remFits};
    assign depthSat = (|quotNext[K_WIDTH-1:DEPTH_WIDTH]) ? {DEPTH_WIDTH{1'b1}}
                                                        : quotNext[DEPTH_WIDTH-1:0];

    // Next-state logic for the matcher/divider sequencer. Finishing a point
    // (unmatched, zero disparity, or last divide step) raises advance, which
    // moves to the next point in the same cycle rather than spending one.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        taken_d     = taken_q;
        found_d     = found_q;
        best_d      = best_q;
        bestDist_d  = bestDist_q;
        wDepth_d    = wDepth_q;
        wIdx_d      = wIdx_q;
        wValid_d    = wValid_q;
        depth_d     = depth_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        dataValid_d = 1'b0;
        disp_d      = disp_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_valid_in) begin
                    for (int k = 0; k < MAX_PTS; k++) begin
                        x1_d[k]     = x_in_1[k*X_WIDTH +: X_WIDTH];
                        y1_d[k]     = y_in_1[k*Y_WIDTH +: Y_WIDTH];
                        x2_d[k]     = x_in_2[k*X_WIDTH +: X_WIDTH];
                        y2_d[k]     = y_in_2[k*Y_WIDTH +: Y_WIDTH];
                        wDepth_d[k] = '0;
                        wIdx_d[k]   = '0;
                    end
                    wValid_d   = '0;
                    taken_d    = '0;
                    n_d        = nAccept;
                    i_d        = '0;
                    j_d        = '0;
                    found_d    = 1'b0;
                    best_d     = '0;
                    bestDist_d = '0;
                    state_d    = S_SEARCH;
                end
            end

            S_SEARCH: begin
                // Strictly-smaller update keeps the lowest index on a tie.
                if (!taken_q[jIdx] && (!found_q || (candDist < bestDist_q))) begin
                    found_d    = 1'b1;
                    best_d     = jIdx;
                    bestDist_d = candDist;
                end
                if (j_q == n_q - CW'(1)) begin
                    state_d = S_RESOLVE;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end

            S_RESOLVE: begin
                if (!found_q || (bestDist_q > MAX_DIST_W)) begin
                    wValid_d[iIdx] = 1'b0;
                    wIdx_d[iIdx]   = '0;
                    wDepth_d[iIdx] = '0;
                    advance        = 1'b1;
                end else begin
                    taken_d[best_q] = 1'b1;
                    wValid_d[iIdx]  = 1'b1;
                    wIdx_d[iIdx]    = best_q;
                    if (bestDisp == '0) begin
                        // Zero disparity means the object is effectively at
                        // infinity in the divide sense; report the nearest bound.
                        wDepth_d[iIdx] = {DEPTH_WIDTH{1'b1}};
                        advance        = 1'b1;
                    end else begin
                        disp_d  = bestDisp;
                        quot_d  = DEPTH_K_W;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIVIDE;
                    end
                end
            end

            S_DIVIDE: begin
                quot_d = quotNext;
                rem_d  = remNext;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(K_WIDTH - 1)) begin
                    wDepth_d[iIdx] = depthSat;
                    advance        = 1'b1;
                end
            end

            S_DONE: begin
                depth_d     = wDepth_q;
                idx_d       = wIdx_q;
                valid_d     = wValid_q;
                dataValid_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            i_d        = i_q + CW'(1);
            j_d        = '0;
            found_d    = 1'b0;
            best_d     = '0;
            bestDist_d = '0;
            state_d    = (i_q + CW'(1) == n_q) ? S_DONE : S_SEARCH;
        end
    end

    // State registers. Reset abandons any set in flight and clears the
    // published results, so no stale pulse or data survives a reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            taken_q     <= '0;
            found_q     <= 1'b0;
            best_q      <= '0;
            bestDist_q  <= '0;
            wValid_q    <= '0;
            valid_q     <= '0;
            dataValid_q <= 1'b0;
            disp_q      <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            for (int k = 0; k < MAX_PTS; k++) begin
                x1_q[k]     <= '0;
                y1_q[k]     <= '0;
                x2_q[k]     <= '0;
                y2_q[k]     <= '0;
                wDepth_q[k] <= '0;
                wIdx_q[k]   <= '0;
                depth_q[k]  <= '0;
                idx_q[k]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            taken_q     <= taken_d;
            found_q     <= found_d;
            best_q      <= best_d;
            bestDist_q  <= bestDist_d;
            wDepth_q    <= wDepth_d;
            wIdx_q      <= wIdx_d;
            wValid_q    <= wValid_d;
            depth_q     <= depth_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            dataValid_q <= dataValid_d;
            disp_q      <= disp_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ready_out       = (state_q == S_IDLE);
    assign data_valid_out  = dataValid_q;
    assign match_valid_out = valid_q;

    for (genvar g = 0; g < MAX_PTS; g++) begin : g_out
        assign depth_out[g*DEPTH_WIDTH +: DEPTH_WIDTH] = depth_q[g];
        assign match_idx_out[g*IW +: IW]              = idx_q[g];
    end

endmodule

// File: tb/tb_stereo_depth_matcher.sv
// ---------------------------------------------------------------------------
// tb_stereo_depth_matcher
//
// Scoreboard bench for stereo_depth_matcher. Every accepted input set is run
// through a behavioural greedy-matching model and the expected outputs and
// latency are queued; each data_valid_out pulse pops and compares one entry.
// Directed sets cover single point, contested centroid, tie/saturation, zero
// disparity, distance gate, continuous handshake and reset mid-divide.
// ---------------------------------------------------------------------------
module tb_stereo_depth_matcher;

    localparam int MAX_PTS     = 4;
    localparam int X_WIDTH     = 11;
    localparam int Y_WIDTH     = 10;
    localparam int DEPTH_WIDTH = 8;
    localparam int K_WIDTH     = 16;
    localparam int DEPTH_K     = 2048;
    localparam int MAX_DIST    = 256;
    localparam int IW          = $clog2(MAX_PTS);

    typedef struct {
        logic [MAX_PTS*DEPTH_WIDTH-1:0] depth;
        logic [MAX_PTS*IW-1:0]          idx;
        logic [MAX_PTS-1:0]             valid;
        longint                         lat;
        longint                         accept;
    } exp_t;

    logic                           clk_in;
    logic                           rst_in;
    logic                           data_valid_in;
    logic                           ready_out;
    logic [IW-1:0]                  num_pts_in;
    logic [MAX_PTS*X_WIDTH-1:0]     x_in_1;
    logic [MAX_PTS*Y_WIDTH-1:0]     y_in_1;
    logic [MAX_PTS*X_WIDTH-1:0]     x_in_2;
    logic [MAX_PTS*Y_WIDTH-1:0]     y_in_2;
    logic [MAX_PTS*DEPTH_WIDTH-1:0] depth_out;
    logic [MAX_PTS*IW-1:0]          match_idx_out;
    logic [MAX_PTS-1:0]             match_valid_out;
    logic                           data_valid_out;

    int     total;
    int     bad;
    int     acceptCount;
    int     abortCount;
    int     pulseCount;
    longint cyc;
    longint lastLat;
    exp_t   sbQ[$];

    int px1 [MAX_PTS];
    int py1 [MAX_PTS];
    int px2 [MAX_PTS];
    int py2 [MAX_PTS];

    stereo_depth_matcher #(
        .MAX_PTS     (MAX_PTS),
        .X_WIDTH     (X_WIDTH),
        .Y_WIDTH     (Y_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .K_WIDTH     (K_WIDTH),
        .DEPTH_K     (DEPTH_K),
        .MAX_DIST    (MAX_DIST)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .data_valid_in   (data_valid_in),
        .ready_out       (ready_out),
        .num_pts_in      (num_pts_in),
        .x_in_1          (x_in_1),
        .y_in_1          (y_in_1),
        .x_in_2          (x_in_2),
        .y_in_2          (y_in_2),
        .depth_out       (depth_out),
        .match_idx_out   (match_idx_out),
        .match_valid_out (match_valid_out),
        .data_valid_out  (data_valid_out)
    );

    // 10 ns clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Edge counter used to time the pulse relative to the accepting edge
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
    end

    // Runaway guard
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int absI(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural model: greedy nearest free centroid in point order,
    // gate on distance, integer divide with saturation, plus the cycle cost.
    function automatic exp_t modelSet(input logic [MAX_PTS*X_WIDTH-1:0] ax1,
                                      input logic [MAX_PTS*Y_WIDTH-1:0] ay1,
                                      input logic [MAX_PTS*X_WIDTH-1:0] ax2,
                                      input logic [MAX_PTS*Y_WIDTH-1:0] ay2,
                                      input logic [IW-1:0]              np);
        exp_t e;
        int   n;
        int   best;
        int   bestD;
        int   d;
        int   disp;
        int   q;
        bit   taken [MAX_PTS];
        e.depth  = '0;
        e.idx    = '0;
        e.valid  = '0;
        e.lat    = 0;
        e.accept = 0;
        n = int'(np) + 1;
        if (n > MAX_PTS) n = MAX_PTS;
        for (int c = 0; c < MAX_PTS; c++) taken[c] = 1'b0;
        for (int p = 0; p < n; p++) begin
            best  = -1;
            bestD = 0;
            for (int c = 0; c < n; c++) begin
                if (!taken[c]) begin
                    d = absI(int'(ax1[p*X_WIDTH +: X_WIDTH]) - int'(ax2[c*X_WIDTH +: X_WIDTH]))
                      + absI(int'(ay1[p*Y_WIDTH +: Y_WIDTH]) - int'(ay2[c*Y_WIDTH +: Y_WIDTH]));
                    if (best < 0 || d < bestD) begin
                        best  = c;
                        bestD = d;
                    end
                end
            end
            e.lat += n + 1;
            if (best >= 0 && bestD <= MAX_DIST) begin
                taken[best]           = 1'b1;
                e.valid[p]            = 1'b1;
                e.idx[p*IW +: IW]     = IW'(best);
                disp = absI(int'(ax1[p*X_WIDTH +: X_WIDTH]) - int'(ax2[best*X_WIDTH +: X_WIDTH]));
                if (disp == 0) begin
                    e.depth[p*DEPTH_WIDTH +: DEPTH_WIDTH] = '1;
                end else begin
                    q = DEPTH_K / disp;
                    if (q > (1 << DEPTH_WIDTH) - 1) q = (1 << DEPTH_WIDTH) - 1;
                    e.depth[p*DEPTH_WIDTH +: DEPTH_WIDTH] = DEPTH_WIDTH'(q);
                    e.lat += K_WIDTH;
                end
            end
        end
        e.lat += 1;
        return e;
    endfunction

    // Scoreboard: push on each accepting edge, pop and compare on each pulse
    always @(negedge clk_in) begin
        exp_t e;
        if (data_valid_in && ready_out && !rst_in) begin
            e = modelSet(x_in_1, y_in_1, x_in_2, y_in_2, num_pts_in);
            e.accept = cyc + 1;
            sbQ.push_back(e);
            acceptCount++;
        end
        if (data_valid_out) begin
            pulseCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                lastLat = cyc - e.accept;
                checkOutput("sb_depth", 64'(depth_out), 64'(e.depth));
                checkOutput("sb_idx", 64'(match_idx_out), 64'(e.idx));
                checkOutput("sb_valid", 64'(match_valid_out), 64'(e.valid));
                checkOutput("sb_latency", 64'(lastLat), 64'(e.lat));
            end
        end
    end

    task automatic clearPts();
        for (int k = 0; k < MAX_PTS; k++) begin
            px1[k] = 0;
            py1[k] = 0;
            px2[k] = 0;
            py2[k] = 0;
        end
    endtask

    task automatic packInputs(input int np);
        for (int k = 0; k < MAX_PTS; k++) begin
            x_in_1[k*X_WIDTH +: X_WIDTH] = X_WIDTH'(px1[k]);
            y_in_1[k*Y_WIDTH +: Y_WIDTH] = Y_WIDTH'(py1[k]);
            x_in_2[k*X_WIDTH +: X_WIDTH] = X_WIDTH'(px2[k]);
            y_in_2[k*Y_WIDTH +: Y_WIDTH] = Y_WIDTH'(py2[k]);
        end
        num_pts_in = IW'(np);
    endtask

    task automatic randomizePts(output int np);
        np = $urandom_range(0, MAX_PTS - 1);
        for (int k = 0; k < MAX_PTS; k++) begin
            px1[k] = $urandom_range(0, 500);
            py1[k] = $urandom_range(0, 200);
            px2[k] = $urandom_range(0, 500);
            py2[k] = $urandom_range(0, 200);
        end
    endtask

    // Offer one set for a single cycle once the block is ready
    task automatic applyStimulus(input int np);
        int budget;
        budget = 300;
        while (!ready_out && budget > 0) begin
            @(posedge clk_in);
            #1;
            budget--;
        end
        if (!ready_out) checkOutput("ready_timeout", 64'd0, 64'd1);
        packInputs(np);
        data_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
    endtask

    // Wait for all queued results to arrive, bounded
    task automatic drainScoreboard();
        int budget;
        budget = 2000;
        while (sbQ.size() != 0 && budget > 0) begin
            @(posedge clk_in);
            budget--;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
        @(negedge clk_in);
    endtask

    initial begin
        int np;
        int pc;
        total         = 0;
        bad           = 0;
        acceptCount   = 0;
        abortCount    = 0;
        pulseCount    = 0;
        cyc           = 0;
        lastLat       = 0;
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        clearPts();
        packInputs(0);

        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("rst_ready", 64'(ready_out), 64'd1);
        checkOutput("rst_dvo", 64'(data_valid_out), 64'd0);
        checkOutput("rst_depth", 64'(depth_out), 64'd0);
        checkOutput("rst_idx", 64'(match_idx_out), 64'd0);
        checkOutput("rst_valid", 64'(match_valid_out), 64'd0);
        @(posedge clk_in);
        #1;

        $display("[TB] single point");
        clearPts();
        px1[0] = 400; py1[0] = 100; px2[0] = 384; py2[0] = 100;
        applyStimulus(0);
        drainScoreboard();
        checkOutput("single_depth", 64'(depth_out[7:0]), 64'd128);
        checkOutput("single_valid", 64'(match_valid_out), 64'b0001);
        checkOutput("single_lat", 64'(lastLat), 64'd19);

        $display("[TB] contested centroid");
        clearPts();
        px1[0] = 100; py1[0] = 100; px1[1] = 105; py1[1] = 100;
        px2[0] = 110; py2[0] = 100; px2[1] = 200; py2[1] = 100;
        applyStimulus(1);
        drainScoreboard();
        checkOutput("contest_depth0", 64'(depth_out[7:0]), 64'd204);
        checkOutput("contest_depth1", 64'(depth_out[15:8]), 64'd21);
        checkOutput("contest_idx", 64'(match_idx_out), 64'h04);
        checkOutput("contest_lat", 64'(lastLat), 64'd39);

        $display("[TB] distance gate and unused slots");
        clearPts();
        px2[0] = 600;
        applyStimulus(0);
        drainScoreboard();
        checkOutput("gate_valid", 64'(match_valid_out), 64'd0);
        checkOutput("gate_depth", 64'(depth_out), 64'd0);
        checkOutput("gate_lat", 64'(lastLat), 64'd3);

        clearPts();
        px2[0] = 256;
        px1[1] = 1000; px2[1] = 1257;
        applyStimulus(1);
        drainScoreboard();
        checkOutput("gate_edge_valid", 64'(match_valid_out), 64'b0001);
        checkOutput("gate_edge_depth", 64'(depth_out[7:0]), 64'd8);

        $display("[TB] tie and saturation");
        clearPts();
        px1[0] = 300; py1[0] = 50;
        px2[0] = 299; py2[0] = 50; px2[1] = 301; py2[1] = 50;
        applyStimulus(1);
        drainScoreboard();
        checkOutput("tie_idx", 64'(match_idx_out), 64'd0);
        checkOutput("tie_depth", 64'(depth_out[7:0]), 64'd255);
        checkOutput("tie_lat", 64'(lastLat), 64'd23);

        $display("[TB] zero disparity");
        clearPts();
        px1[0] = 300; py1[0] = 50;
        px2[0] = 300; py2[0] = 60; px2[1] = 500; py2[1] = 50;
        applyStimulus(1);
        drainScoreboard();
        checkOutput("zero_depth", 64'(depth_out[7:0]), 64'd255);
        checkOutput("zero_lat", 64'(lastLat), 64'd7);

        $display("[TB] random sets");
        for (int r = 0; r < 8; r++) begin
            randomizePts(np);
            applyStimulus(np);
        end
        drainScoreboard();

        $display("[TB] continuous handshake");
        data_valid_in = 1'b1;
        for (int r = 0; r < 120; r++) begin
            randomizePts(np);
            packInputs(np);
            @(posedge clk_in);
            #1;
        end
        data_valid_in = 1'b0;
        drainScoreboard();

        $display("[TB] reset during divide");
        @(posedge clk_in);
        #1;
        clearPts();
        px1[0] = 400; py1[0] = 100; px2[0] = 384; py2[0] = 100;
        applyStimulus(0);
        repeat (8) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        sbQ.delete();
        abortCount++;
        pc = pulseCount;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("abort_ready", 64'(ready_out), 64'd1);
        checkOutput("abort_depth", 64'(depth_out), 64'd0);
        checkOutput("abort_valid", 64'(match_valid_out), 64'd0);
        repeat (30) @(posedge clk_in);
        #1;
        checkOutput("abort_no_pulse", 64'(pulseCount), 64'(pc));

        clearPts();
        px1[0] = 100; py1[0] = 100; px1[1] = 105; py1[1] = 100;
        px2[0] = 110; py2[0] = 100; px2[1] = 200; py2[1] = 100;
        applyStimulus(1);
        drainScoreboard();
        checkOutput("after_abort_depth1", 64'(depth_out[15:8]), 64'd21);

        checkOutput("pulse_count", 64'(pulseCount), 64'(acceptCount - abortCount));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
